psram_req_sequencer: RTL and testbench
======================================

// Module: psram_req_sequencer
// PURPOSE
//  Upstream stage of the PSRAM top: queues single-word read/write requests from user logic (valid/ready) and
//  turns each into one level-held read_sw/write_sw transaction on the psram block. Holds each strobe until
//  endcommand, then returns read data as a one-cycle response. Runs on mem_clk.
// PARAMETERS
//  FIFO_DEPTH      4   request queue entries; power of 2, >=2
//  ADDR_W         24   PSRAM word address width
//  DATA_W         16   data word width
//  GUARD_CYCLES    4   cycles after strobe assertion during which endcommand is ignored; >=1
//  TIMEOUT_CYCLES 64   watchdog limit in WAIT (only with PSRAM_SEQ_TIMEOUT_EN)
// PORTS
//  mem_clk          in   1       sole clock; all state on posedge
//  rst_n            in   1       asynchronous, active-low reset
//  req_valid        in   1       request offered
//  req_ready        out  1       queue not full; push when req_valid && req_ready
//  req_write        in   1       1 = write, 0 = read
//  req_addr         in   ADDR_W  request address
//  req_wdata        in   DATA_W  write data (ignored for reads)
//  rsp_valid        out  1       one-cycle pulse: rsp_rdata holds read result
//  rsp_rdata        out  DATA_W  read data, stable until next rsp_valid
//  rsp_timeout      out  1       one-cycle pulse on watchdog abort (tied 0 without macro)
//  busy             out  1       transaction in flight or queue non-empty
//  psram_qpi_on     in   1       psram initialised to QPI; no issue while low
//  psram_address    out  ADDR_W  to psram.address
//  psram_data_in    out  DATA_W  to psram.data_in
//  psram_read_sw    out  1       to psram.read_sw
//  psram_write_sw   out  1       to psram.write_sw
//  psram_data_out   in   DATA_W  from psram.data_out
//  psram_endcommand in   1       from psram.endcommand
// BEHAVIOUR
//  Reset: all outputs 0 (req_ready 1 one cycle after rst_n rises); queue emptied; state IDLE.
//  Queue: FIFO, push on req_valid&&req_ready, pop only in IDLE->ISSUE; req_ready = !full; no push when full
//   even if a pop occurs the same cycle. Pointers wrap modulo FIFO_DEPTH; count width clog2(FIFO_DEPTH)+1.
//  FSM: IDLE -> ISSUE -> GUARD -> WAIT -> GAP -> IDLE.
//   IDLE : if queue non-empty && psram_qpi_on: pop head, register addr/wdata/write onto psram_* outputs.
//   ISSUE: assert exactly one of psram_write_sw / psram_read_sw (never both, ever); load guard counter.
//   GUARD: strobe held; count GUARD_CYCLES; psram_endcommand ignored.
//   WAIT : strobe held; on psram_endcommand=1: drop strobe next edge; if read, capture psram_data_out into
//          rsp_rdata and pulse rsp_valid in the same edge. Writes produce no response.
//   GAP  : one cycle, both strobes 0, so the driver sees deassertion before the next request.
//  Latency: read request popped at edge N -> rsp_valid no earlier than N+2+GUARD_CYCLES.
//  Throughput: at most one transaction per (GUARD_CYCLES+4) cycles; back-to-back requests always pass GAP.
//  psram_qpi_on falling mid-transaction: current transaction completes; no new issue until it returns high.
//  psram_address/psram_data_in stable from ISSUE through GAP; unchanged in IDLE.
//  rst_n asserted mid-transaction: strobes drop asynchronously, rsp_valid not produced, queue flushed.
//  busy = (state != IDLE) || !empty.
// CONFIGURATION
//  PSRAM_SEQ_TIMEOUT_EN defined: WAIT counts cycles; at TIMEOUT_CYCLES without endcommand, drop strobe,
//   pulse rsp_timeout (and for reads rsp_valid is NOT pulsed), go GAP. Undefined: WAIT waits forever,
//   rsp_timeout tied 0, no counter logic synthesised.
// STRUCTURE
//  Package psram_pkg: FSM state encodings (IDLE..GAP), ADDR_W/DATA_W defaults, opcode bit (RD=0, WR=1).
//  Sub-module psram_req_fifo: synchronous FIFO, width 1+ADDR_W+DATA_W, depth FIFO_DEPTH, full/empty out.
//  FSM, guard/timeout counters and response register stay in psram_req_sequencer.
// TESTING
//  1 Write 0x00_0010 <- 0xBEEF, endcommand model after 12 cyc -> write_sw high 12+ cyc, no rsp_valid, GAP seen.
//  2 Read 0x00_0010, model returns 0xBEEF -> single rsp_valid, rsp_rdata=0xBEEF, read_sw/write_sw never both 1.
//  3 Push 5 requests with FIFO_DEPTH=4 and qpi_on=0 -> req_ready low after 4th; qpi_on=1 -> issued in order.
//  4 endcommand held 1 from strobe assert -> ignored for GUARD_CYCLES=4, transaction ends at cycle 5 of strobe.
//  5 rst_n low during WAIT of a read -> strobes 0 immediately, no rsp_valid, busy=0, req_ready=1 after release.
//  6 PSRAM_SEQ_TIMEOUT_EN, endcommand stuck 0 -> rsp_timeout pulse after 64 WAIT cycles, next request proceeds.

Source files
------------

// File: rtl/psram_pkg.sv
// Shared encodings and defaults for the PSRAM request sequencer.
package psram_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_GUARD = 3'd2,
    ST_WAIT  = 3'd3,
    ST_GAP   = 3'd4
  } seq_state_t;

  localparam int ADDR_W_DEF = 24;
  localparam int DATA_W_DEF = 16;

  localparam logic OP_RD = 1'b0;
  localparam logic OP_WR = 1'b1;

endpackage

// File: rtl/psram_req_fifo.sv
// Request queue: synchronous FIFO with a combinational head word, DEPTH a power of 2.
module psram_req_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 41
) (
  input  logic             mem_clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge mem_clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge mem_clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/psram_req_sequencer.sv
// Turns queued single-word requests into level-held read_sw/write_sw transactions on the psram block.
// Optional watchdog in WAIT: define PSRAM_SEQ_TIMEOUT_EN.
//
// state | meaning
// IDLE  | waiting for a queued request and psram_qpi_on
// ISSUE | request latched onto psram_*; strobe asserts on exit
// GUARD | strobe held, endcommand ignored for GUARD_CYCLES
// WAIT  | strobe held until endcommand (or watchdog)
// GAP   | one cycle with both strobes low
module psram_req_sequencer
  import psram_pkg::*;
#(
  parameter int FIFO_DEPTH   = 4,
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int GUARD_CYCLES = 4
`ifdef PSRAM_SEQ_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 64
`endif
) (
  input  logic              mem_clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_timeout,
  output logic              busy,
  input  logic              psram_qpi_on,
  output logic [ADDR_W-1:0] psram_address,
  output logic [DATA_W-1:0] psram_data_in,
  output logic              psram_read_sw,
  output logic              psram_write_sw,
  input  logic [DATA_W-1:0] psram_data_out,
  input  logic              psram_endcommand
);
  localparam int FW = 1 + ADDR_W + DATA_W;
  localparam int GW = $clog2(GUARD_CYCLES + 1);

  seq_state_t      state;
  logic            rdy_en;
  logic            cur_write;
  logic [GW-1:0]   guard_cnt;
  logic [FW-1:0]   head;
  logic            fifo_full;
  logic            fifo_empty;
  logic            push;
  logic            pop;

  // req_ready stays low until the first edge after reset release
  assign req_ready = rdy_en && !fifo_full;
  assign push      = req_valid && req_ready;
  assign pop       = (state == ST_IDLE) && !fifo_empty && psram_qpi_on;
  assign busy      = (state != ST_IDLE) || !fifo_empty;

  psram_req_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (FW)
  ) u_fifo (
    .mem_clk (mem_clk),
    .rst_n   (rst_n),
    .push    (push),
    .din     ({req_write, req_addr, req_wdata}),
    .pop     (pop),
    .dout    (head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

`ifdef PSRAM_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] to_cnt;
`else
  assign rsp_timeout = 1'b0;
`endif

  always_ff @(posedge mem_clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ST_IDLE;
      rdy_en         <= 1'b0;
      cur_write      <= OP_RD;
      guard_cnt      <= '0;
      psram_address  <= '0;
      psram_data_in  <= '0;
      psram_read_sw  <= 1'b0;
      psram_write_sw <= 1'b0;
      rsp_valid      <= 1'b0;
      rsp_rdata      <= '0;
`ifdef PSRAM_SEQ_TIMEOUT_EN
      to_cnt         <= '0;
      rsp_timeout    <= 1'b0;
`endif
    end else begin
      rdy_en    <= 1'b1;
      rsp_valid <= 1'b0;
`ifdef PSRAM_SEQ_TIMEOUT_EN
      rsp_timeout <= 1'b0;
`endif
      case (state)
        ST_IDLE: begin
          if (pop) begin
            {cur_write, psram_address, psram_data_in} <= head;
            state <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          psram_write_sw <= (cur_write == OP_WR);
          psram_read_sw  <= (cur_write == OP_RD);
          guard_cnt      <= GW'(GUARD_CYCLES - 1);
          state          <= ST_GUARD;
        end
        ST_GUARD: begin
          if (guard_cnt == '0) begin
            state <= ST_WAIT;
`ifdef PSRAM_SEQ_TIMEOUT_EN
            to_cnt <= TW'(TIMEOUT_CYCLES - 1);
`endif
          end else begin
            guard_cnt <= guard_cnt - GW'(1);
          end
        end
        ST_WAIT: begin
          if (psram_endcommand) begin
            psram_read_sw  <= 1'b0;
            psram_write_sw <= 1'b0;
            if (cur_write == OP_RD) begin
              rsp_rdata <= psram_data_out;
              rsp_valid <= 1'b1;
            end
            state <= ST_GAP;
          end
`ifdef PSRAM_SEQ_TIMEOUT_EN
          else if (to_cnt == '0) begin
            psram_read_sw  <= 1'b0;
            psram_write_sw <= 1'b0;
            rsp_timeout    <= 1'b1;
            state          <= ST_GAP;
          end else begin
            to_cnt <= to_cnt - TW'(1);
          end
`endif
        end
        ST_GAP:  state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_psram_req_sequencer.sv
// Directed bench for psram_req_sequencer: vector table plus reset, backpressure and watchdog sequences.
module tb_psram_req_sequencer;

  logic        mem_clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [23:0] req_addr;
  logic [15:0] req_wdata;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic        rsp_timeout;
  logic        busy;
  logic        psram_qpi_on;
  logic [23:0] psram_address;
  logic [15:0] psram_data_in;
  logic        psram_read_sw;
  logic        psram_write_sw;
  logic [15:0] psram_data_out;
  logic        psram_endcommand;

  psram_req_sequencer dut (
    .mem_clk          (mem_clk),
    .rst_n            (rst_n),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_write        (req_write),
    .req_addr         (req_addr),
    .req_wdata        (req_wdata),
    .rsp_valid        (rsp_valid),
    .rsp_rdata        (rsp_rdata),
    .rsp_timeout      (rsp_timeout),
    .busy             (busy),
    .psram_qpi_on     (psram_qpi_on),
    .psram_address    (psram_address),
    .psram_data_in    (psram_data_in),
    .psram_read_sw    (psram_read_sw),
    .psram_write_sw   (psram_write_sw),
    .psram_data_out   (psram_data_out),
    .psram_endcommand (psram_endcommand)
  );

  always #5 mem_clk = ~mem_clk;

  typedef struct {
    logic        wr;
    logic [23:0] addr;
    logic [15:0] wdata;
    int          ec_delay;
    logic [15:0] model;
    int          exp_strobe;
    int          exp_rsp;
    logic [15:0] exp_rdata;
  } vec_t;

  vec_t vecs[6];

  int total = 0;
  int passed = 0;

  // psram model and monitor state, all updated on the falling edge
  int          ec_delay = 5;
  int          hi_cnt = 0;
  int          cyc = 0;
  int          strobe_cycles = 0;
  int          rsp_count = 0;
  int          timeout_cnt = 0;
  int          both_err = 0;
  logic        prev_strobe = 1'b0;
  logic        mon_wr = 1'b0;
  logic [23:0] mon_addr = '0;
  logic [15:0] mon_din = '0;
  logic [23:0] rise_addr[$];
  int          rise_cyc[$];

  always @(negedge mem_clk) begin
    logic strobe;
    strobe = psram_read_sw || psram_write_sw;
    cyc++;
    if (strobe) hi_cnt++;
    else hi_cnt = 0;
    psram_endcommand = strobe && (hi_cnt >= ec_delay);
    if (psram_read_sw && psram_write_sw) both_err++;
    if (strobe) begin
      strobe_cycles++;
      mon_wr   = psram_write_sw;
      mon_addr = psram_address;
      mon_din  = psram_data_in;
      if (!prev_strobe) begin
        rise_addr.push_back(psram_address);
        rise_cyc.push_back(cyc);
      end
    end
    prev_strobe = strobe;
    if (rsp_valid) rsp_count++;
    if (rsp_timeout) timeout_cnt++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    else passed++;
  endtask

  task automatic tick();
    @(negedge mem_clk);
    #1;
  endtask

  task automatic clear_mon();
    strobe_cycles = 0;
    rsp_count = 0;
    timeout_cnt = 0;
    rise_addr.delete();
    rise_cyc.delete();
  endtask

  task automatic push_req(input logic wr, input logic [23:0] a, input logic [15:0] d);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = a;
    req_wdata = d;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic run_txn(input logic wr, input logic [23:0] a, input logic [15:0] d, input string tag);
    bit done;
    done = 1'b0;
    tick();
    clear_mon();
    push_req(wr, a, d);
    for (int i = 0; i < 300 && !done; i++) begin
      tick();
      if (strobe_cycles > 0 && !psram_read_sw && !psram_write_sw && !busy) done = 1'b1;
    end
    check({tag, "_completed"}, done, 1'b1);
  endtask

  initial begin
    bit done;
    vecs[0] = '{1'b1, 24'h000010, 16'hBEEF, 12, 16'h0000, 12, 0, 16'h0000};
    vecs[1] = '{1'b0, 24'h000010, 16'h0000,  7, 16'hBEEF,  7, 1, 16'hBEEF};
    vecs[2] = '{1'b0, 24'hABCDEF, 16'h0000,  1, 16'h1234,  5, 1, 16'h1234};
    vecs[3] = '{1'b1, 24'hFFFFFF, 16'h5A5A,  5, 16'hFFFF,  5, 0, 16'h1234};
    vecs[4] = '{1'b0, 24'h000001, 16'h0000,  6, 16'h0F0F,  6, 1, 16'h0F0F};
    vecs[5] = '{1'b0, 24'h123456, 16'h0000,  5, 16'h8001,  5, 1, 16'h8001};

    rst_n = 1'b1;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr = '0;
    req_wdata = '0;
    psram_qpi_on = 1'b1;
    psram_data_out = '0;
    psram_endcommand = 1'b0;
    #3 rst_n = 1'b0;
    #5;
    check("rst_req_ready", req_ready, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_strobes", {psram_read_sw, psram_write_sw}, 2'b00);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_addr", psram_address, 24'h0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check("ready_after_release", req_ready, 1'b1);

    for (int v = 0; v < 6; v++) begin
      ec_delay = vecs[v].ec_delay;
      psram_data_out = vecs[v].model;
      run_txn(vecs[v].wr, vecs[v].addr, vecs[v].wdata, $sformatf("vec%0d", v));
      check($sformatf("vec%0d_strobe_cycles", v), strobe_cycles, vecs[v].exp_strobe);
      check($sformatf("vec%0d_rsp_count", v), rsp_count, vecs[v].exp_rsp);
      check($sformatf("vec%0d_rsp_rdata", v), rsp_rdata, vecs[v].exp_rdata);
      check($sformatf("vec%0d_psram_address", v), mon_addr, vecs[v].addr);
      check($sformatf("vec%0d_strobe_kind", v), mon_wr, vecs[v].wr);
      if (vecs[v].wr) check($sformatf("vec%0d_data_in", v), mon_din, vecs[v].wdata);
      check($sformatf("vec%0d_gap_low", v), {psram_read_sw, psram_write_sw}, 2'b00);
    end

    // backpressure with psram not yet in QPI mode, then in-order drain
    psram_qpi_on = 1'b0;
    ec_delay = 5;
    tick();
    clear_mon();
    for (int i = 0; i < 5; i++) begin
      check($sformatf("fill%0d_req_ready", i), req_ready, (i < 4) ? 1'b1 : 1'b0);
      push_req(1'b0, 24'h000100 + 24'(i), 16'h0);
    end
    for (int i = 0; i < 10; i++) tick();
    check("qpi_off_no_strobe", strobe_cycles, 0);
    check("qpi_off_busy", busy, 1'b1);
    psram_qpi_on = 1'b1;
    done = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      tick();
      if (!busy) done = 1'b1;
    end
    check("drain_completed", done, 1'b1);
    check("drain_txn_count", rise_addr.size(), 4);
    for (int i = 0; i < 4 && i < rise_addr.size(); i++)
      check($sformatf("drain%0d_addr", i), rise_addr[i], 24'h000100 + 24'(i));
    for (int i = 1; i < 4 && i < rise_cyc.size(); i++)
      check($sformatf("drain%0d_spacing", i), rise_cyc[i] - rise_cyc[i-1], 8);
    check("drain_rsp_count", rsp_count, 4);

    // reset during WAIT of a read with a second request still queued
    ec_delay = 100000;
    tick();
    clear_mon();
    push_req(1'b0, 24'h000200, 16'h0);
    push_req(1'b1, 24'h000201, 16'h7777);
    done = 1'b0;
    for (int i = 0; i < 50 && !done; i++) begin
      tick();
      if (strobe_cycles >= 7) done = 1'b1;
    end
    check("midrst_reached_wait", done, 1'b1);
    check("midrst_read_sw_high", psram_read_sw, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_strobes_low", {psram_read_sw, psram_write_sw}, 2'b00);
    check("midrst_busy", busy, 1'b0);
    ec_delay = 5;
    tick();
    rst_n = 1'b1;
    clear_mon();
    tick();
    tick();
    check("midrst_ready_after", req_ready, 1'b1);
    for (int i = 0; i < 15; i++) tick();
    check("midrst_no_rsp", rsp_count, 0);
    check("midrst_queue_flushed", strobe_cycles, 0);
    check("midrst_idle", busy, 1'b0);

`ifdef PSRAM_SEQ_TIMEOUT_EN
    ec_delay = 100000;
    psram_data_out = 16'hDEAD;
    run_txn(1'b0, 24'h000300, 16'h0, "to");
    check("to_strobe_cycles", strobe_cycles, 68);
    check("to_pulse_count", timeout_cnt, 1);
    check("to_no_rsp", rsp_count, 0);
    ec_delay = 6;
    psram_data_out = 16'h4242;
    run_txn(1'b0, 24'h000301, 16'h0, "after_to");
    check("after_to_rsp_count", rsp_count, 1);
    check("after_to_rdata", rsp_rdata, 16'h4242);
    check("after_to_no_timeout", timeout_cnt, 0);
`else
    ec_delay = 6;
    psram_data_out = 16'h4242;
    run_txn(1'b0, 24'h000301, 16'h0, "final");
    check("final_rdata", rsp_rdata, 16'h4242);
    check("timeout_tied_low", timeout_cnt, 0);
`endif

    check("never_both_strobes", both_err, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
